// File: rtl/imap_biu.sv
// Bus interface unit that fills the input-feature-map buffer from external memory.
// It splits a load into read bursts, one outstanding at a time, and writes each beat to the buffer.
module imap_biu #(
  parameter int BURST_MAX = 16,
  parameter int BUF_WORDS = 28672
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [31:0] cmd_ext_addr,
  input  logic [14:0] cmd_buf_addr,
  input  logic [15:0] cmd_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic [7:0]  req_len,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [63:0] rsp_data,
  input  logic        rsp_last,
  output logic [31:0] imap_waddr,
  output logic [63:0] imap_wdata,
  output logic        imap_wen
);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, FIN} state_e;

  localparam logic [8:0]  BURST_MAX_W = 9'(BURST_MAX);
  localparam logic [16:0] BUF_WORDS_W = 17'(BUF_WORDS);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] ext_addr_q, ext_addr_d;
  logic [14:0] buf_addr_q, buf_addr_d;
  logic [15:0] remain_q, remain_d;
  logic [8:0]  burst_beats_q, burst_beats_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [7:0]  req_len_q, req_len_d;
  logic        rsp_ready_q, rsp_ready_d;
  logic [14:0] imap_waddr_q, imap_waddr_d;
  logic [63:0] imap_wdata_q, imap_wdata_d;
  logic        imap_wen_q, imap_wen_d;

  logic [9:0]  to_boundary;
  logic [8:0]  remain_clip;
  logic [8:0]  beats_calc;
  logic [16:0] fill_end;
  logic        beat_acc;
  logic        final_beat;

  // Burst size: the smallest of the burst limit, the words still to load and the room left in the 4KB page.
  // NOTE: always_comb uses blocking '=' so later lines see the values computed above them.
  always_comb begin
    to_boundary = 10'd512 - {1'b0, ext_addr_q[11:3]};
    remain_clip = (remain_q > {7'd0, BURST_MAX_W}) ? BURST_MAX_W : remain_q[8:0];
    beats_calc  = (to_boundary < {1'b0, remain_clip}) ? to_boundary[8:0] : remain_clip;
    fill_end    = {2'b00, buf_addr_q} + {1'b0, remain_q};
  end

  // NOTE: every _d gets a default before the case, so no path can leave a latch behind.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    ext_addr_d    = ext_addr_q;
    buf_addr_d    = buf_addr_q;
    remain_d      = remain_q;
    burst_beats_d = burst_beats_q;
    beat_cnt_d    = beat_cnt_q;
    req_valid_d   = req_valid_q;
    req_addr_d    = req_addr_q;
    req_len_d     = req_len_q;
    rsp_ready_d   = rsp_ready_q;
    imap_waddr_d  = imap_waddr_q;
    imap_wdata_d  = imap_wdata_q;
    imap_wen_d    = 1'b0;
    beat_acc      = rsp_valid && rsp_ready_q;
    final_beat    = (beat_cnt_q == burst_beats_q - 9'd1);

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // busy is still high in the cycle done pulses, so a start there is dropped.
        if (cmd_start && !busy_q) begin
          ext_addr_d = cmd_ext_addr;
          buf_addr_d = cmd_buf_addr;
          remain_d   = cmd_len;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (remain_q == 16'd0) begin
          state_d = FIN;
        end else if (fill_end > BUF_WORDS_W) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (!req_valid_q) begin
          req_valid_d   = 1'b1;
          req_addr_d    = ext_addr_q & 32'hFFFF_FFF8;
          req_len_d     = 8'(beats_calc - 9'd1);
          burst_beats_d = beats_calc;
          beat_cnt_d    = 9'd0;
        end else if (req_ready) begin
          req_valid_d = 1'b0;
          rsp_ready_d = 1'b1;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (beat_acc) begin
          imap_wen_d   = 1'b1;
          imap_wdata_d = rsp_data;
          imap_waddr_d = buf_addr_q;
          buf_addr_d   = buf_addr_q + 15'd1;
          remain_d     = remain_q - 16'd1;
          beat_cnt_d   = beat_cnt_q + 9'd1;
          // The beat count ends the burst; rsp_last is only cross-checked against it.
          if (final_beat) begin
            if (!rsp_last) err_d = 1'b1;
            ext_addr_d  = ext_addr_q + {20'd0, burst_beats_q, 3'b000};
            rsp_ready_d = 1'b0;
            state_d     = (remain_q == 16'd1) ? FIN : REQ;
          end else if (rsp_last) begin
            err_d = 1'b1;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: flops use non-blocking '<=' so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      ext_addr_q    <= '0;
      buf_addr_q    <= '0;
      remain_q      <= '0;
      burst_beats_q <= '0;
      beat_cnt_q    <= '0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_len_q     <= '0;
      rsp_ready_q   <= 1'b0;
      imap_waddr_q  <= '0;
      imap_wdata_q  <= '0;
      imap_wen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      ext_addr_q    <= ext_addr_d;
      buf_addr_q    <= buf_addr_d;
      remain_q      <= remain_d;
      burst_beats_q <= burst_beats_d;
      beat_cnt_q    <= beat_cnt_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_len_q     <= req_len_d;
      rsp_ready_q   <= rsp_ready_d;
      imap_waddr_q  <= imap_waddr_d;
      imap_wdata_q  <= imap_wdata_d;
      imap_wen_q    <= imap_wen_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign req_valid  = req_valid_q;
  assign req_addr   = req_addr_q;
  assign req_len    = req_len_q;
  assign rsp_ready  = rsp_ready_q;
  assign imap_waddr = {17'd0, imap_waddr_q};
  assign imap_wdata = imap_wdata_q;
  assign imap_wen   = imap_wen_q;

endmodule

// File: doc/imap_biu.md
Name: imap_biu

Overview:
- Bus interface unit that fills the input-feature-map buffer from external memory.
- Accepts a load command (external byte base, buffer word base, word count) and issues read bursts on a simple valid/ready request channel.
- Receives 64-bit response beats and drives registered imap_waddr/imap_wdata/imap_wen into the imap buffer, which is made of seven 4Kx64 SRAMs.
- The buffer word address is linear: bits [14:12] select the SRAM, bits [11:0] select the row.

Parameters:
- BURST_MAX, 16, maximum beats per read burst (power of two, 1..256).
- BUF_WORDS, 28672, imap buffer capacity in 64-bit words (7*4096).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_start  in  1  one-cycle load pulse; ignored while busy=1
- cmd_ext_addr  in  32  external byte base address; bits [2:0] are ignored (8-byte aligned)
- cmd_buf_addr  in  15  buffer start word address
- cmd_len  in  16  number of 64-bit words to load
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of load
- err  out  1  sticky error; cleared by the next accepted cmd_start
- req_valid  out  1  burst request valid
- req_ready  in  1  burst request accepted
- req_addr  out  32  burst byte address
- req_len  out  8  beats-1
- rsp_valid  in  1  response beat valid
- rsp_ready  out  1  response beat accept
- rsp_data  in  64  response beat data
- rsp_last  in  1  last beat of burst
- imap_waddr  out  32  buffer word address; bits [31:15] are zero
- imap_wdata  out  64  buffer write data
- imap_wen  out  1  buffer write enable

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- FSM states: IDLE, CHECK, REQ, DATA, FIN.
- IDLE:
  - On cmd_start, latch the three cmd fields, clear err, set busy=1, go to CHECK.
  - cmd_start arriving while not in IDLE is dropped.
- CHECK (one cycle):
  - If cmd_len==0, go to FIN with no bus traffic.
  - If cmd_buf_addr+cmd_len > BUF_WORDS (17-bit compare), set err=1 and go to FIN with no bus traffic.
  - Otherwise go to REQ.
- REQ:
  - req_valid=1 and holds stable until req_ready.
  - Burst beats = min(BURST_MAX, remaining words, words left to the next 4KB external boundary). Words left to the boundary = 512 - ext_addr[11:3].
  - req_len = beats-1.
  - On the req_valid&req_ready handshake, go to DATA.
- DATA:
  - rsp_ready=1. Only one burst is outstanding at a time.
  - Each accepted beat (rsp_valid&rsp_ready) registers imap_wen=1, imap_wdata=rsp_data, imap_waddr=current buffer address on the next cycle.
  - The buffer address then increments by 1 and the remaining count decrements by 1.
  - When the beat counter of the current burst reaches its final beat:
    - if rsp_last=0 on that beat, set err=1;
    - ext_addr advances by beats*8;
    - go to REQ if remaining>0, else FIN.
  - rsp_last=1 on an earlier beat sets err=1 and does not terminate the burst. Beat counting is authoritative.
- FIN: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Write latency: a beat accepted in cycle N produces imap_wen in cycle N+1.
- Back-to-back beats produce consecutive imap_wen cycles with no bubble. imap_wen=0 whenever no beat was accepted in the prior cycle.
- done asserts no earlier than the cycle after the final imap_wen.
- Address crossing an SRAM boundary (e.g. 4095 -> 4096) is plain linear increment; no special handling.
- err does not abort the load, except for the CHECK overflow case.
- Reset mid-load: all state clears immediately.
  - In-flight bus responses after reset deassertion are accepted with rsp_ready=0 only in the sense that the bus must be reset alongside; no recovery is required.

Test Plan:
- Basic load: cmd_ext_addr=0x1000, cmd_buf_addr=0, cmd_len=40, BURST_MAX=16, req_ready=1 -> three requests with req_len 15/15/7 at 0x1000/0x1080/0x1100; 40 imap_wen pulses at waddr 0..39 carrying the data in order; done one cycle after the last write; err=0.
- 4KB split: cmd_ext_addr=0x1FF0, cmd_len=8 -> first request 0x1FF0 with req_len=1, second request 0x2000 with req_len=5; waddr contiguous.
- SRAM boundary and backpressure: cmd_buf_addr=4094, cmd_len=4, rsp_valid toggling every other cycle -> imap_wen only in the cycles after accepted beats; waddr sequence 4094, 4095, 4096, 4097.
- Zero and overflow: cmd_len=0 -> no req_valid, done in the 3rd cycle after start, err=0. cmd_buf_addr=28600 with cmd_len=100 -> no req_valid, done, err=1.
- Protocol errors: rsp_last missing on the final beat -> err=1 and the next burst is still requested. cmd_start while busy -> ignored, latched fields unchanged.
- Async reset asserted mid-DATA -> all outputs 0 immediately; after release, a new cmd_start performs a clean load.
